tt_um_taghreed_eialsalman_mux_rr_arbiter: RTL and testbench
===========================================================

// Module: tt_um_taghreed_eialsalman_mux_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for the shared 2:1 select datapath.
//   Two requesters (A, B) compete for the one mux output. The block owns the select line and
//   issues one-hot grants. A burst limit stops either side starving the other.
//   The selected data is registered to the output with a valid flag.
// PARAMETERS
//   DATA_W     8   width of each requester data bus and of out_data
//   MAX_BURST  4   max consecutive transfers per owner while the other side waits (>=1)
// PORTS
//   clk       in   1       clock, all state on rising edge
//   rst       in   1       synchronous reset, active-high
//   req_a     in   1       requester A wants the datapath; data_a valid while high
//   req_b     in   1       requester B wants the datapath; data_b valid while high
//   data_a    in   DATA_W  requester A data
//   data_b    in   DATA_W  requester B data
//   gnt_a     out  1       A owns datapath this cycle (registered)
//   gnt_b     out  1       B owns datapath this cycle (registered)
//   sel       out  1       mux select: 0=A, 1=B (registered, equals gnt_b)
//   out_valid out  1       out_data holds a transferred word
//   out_data  out  DATA_W  registered mux output
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, gnt_a=gnt_b=0, sel=0, out_valid=0, out_data=0,
//     burst_cnt=0, last=B (so A wins the first tie). Applies mid-burst; any in-flight word is dropped.
//   States: IDLE, OWN_A, OWN_B. gnt_a=(state==OWN_A), gnt_b=(state==OWN_B); never both high.
//   Transfer: xfer_a = gnt_a & req_a, xfer_b = gnt_b & req_b (same cycle).
//   IDLE: both req -> owner != last; one req -> that one; none -> stay IDLE.
//     Grant is visible the cycle after req is sampled (1-cycle arbitration latency).
//   OWN_X (X=A/B, Y=other):
//     req_X=0 -> req_Y ? OWN_Y : IDLE (owner release, no transfer this cycle).
//     xfer_X with burst_cnt==MAX_BURST-1 and req_Y -> OWN_Y (forced handover).
//     xfer_X with burst_cnt==MAX_BURST-1 and !req_Y -> stay OWN_X, burst_cnt<=0.
//     otherwise xfer_X -> stay OWN_X, burst_cnt<=burst_cnt+1.
//   Any state change: burst_cnt<=0; last<=the owner being left (on entry to IDLE too).
//   Datapath: xfer_a -> out_data<=data_a, out_valid<=1; xfer_b -> out_data<=data_b, out_valid<=1;
//     else out_valid<=0, out_data holds. Data latency: 1 cycle from transfer.
//   sel changes only on grant change; with no grant, sel holds its last value.
//   MAX_BURST=1: strict alternation whenever both request every cycle.
//   Requests that drop and rise in the same cycle are not visible. Only the level at the edge counts.
// TESTING
//   1 Reset: rst=1 2 cycles with req_a=req_b=1 -> gnt=00, out_valid=0, out_data=0, sel=0.
//   2 Single: req_a=1 data_a=8'h5A for 3 cycles -> gnt_a from cycle 1, out_valid=1 with
//     out_data=8'h5A from cycle 2; drop req_a -> IDLE, out_valid=0 next cycle.
//   3 Tie + fairness: from reset req_a=req_b=1 held, MAX_BURST=4 -> A gets 4 transfers, B gets 4,
//     then A gets 4; sel toggles every 4 cycles. No gap cycle between owners.
//   4 Early release: OWN_A after 2 transfers, req_a->0 while req_b=1 -> gnt_b next cycle, burst_cnt=0.
//   5 Burst w/o contender: req_a only for 10 cycles -> gnt_a continuous, 10 contiguous valids.
//   6 Reset mid-burst: OWN_B, burst_cnt=2, rst=1 one cycle -> all outputs zero next cycle;
//     with req_a=req_b=1 after reset -> A granted first.

Source files
------------

// File: rtl/tt_um_taghreed_eialsalman_mux_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// tt_um_taghreed_eialsalman_mux_rr_arbiter_if
//   Bundles the request/data and grant/output signals of the 2:1 round-robin
//   mux arbiter.
//   master : requester side (drives req_*/data_*, observes grants and output)
//   slave  : arbiter side   (observes req_*/data_*, drives grants and output)
//   Signals:
//     req_a, req_b     requester wants the datapath (data valid while high)
//     data_a, data_b   requester data, DATA_W bits
//     gnt_a, gnt_b     one-hot registered grants
//     sel              mux select, 0=A 1=B
//     out_valid        out_data holds a transferred word
//     out_data         registered mux output, DATA_W bits
// ----------------------------------------------------------------------------
interface tt_um_taghreed_eialsalman_mux_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req_a;
    logic              req_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output req_a, req_b, data_a, data_b,
        input  gnt_a, gnt_b, sel, out_valid, out_data
    );

    modport slave (
        input  req_a, req_b, data_a, data_b,
        output gnt_a, gnt_b, sel, out_valid, out_data
    );
endinterface

// File: rtl/tt_um_taghreed_eialsalman_mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tt_um_taghreed_eialsalman_mux_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 2:1 select datapath.
//   Two requesters compete for one registered mux output. Ties go to the side
//   that did not own the datapath last; a burst limit forces a handover after
//   MAX_BURST consecutive transfers when the other side is waiting.
//   Ports:
//     clk   in   clock, all state on rising edge
//     rst   in   synchronous reset, active-high
//     bus   slave modport of tt_um_taghreed_eialsalman_mux_rr_arbiter_if
//   Parameters:
//     DATA_W     data width of both requesters and of out_data
//     MAX_BURST  max consecutive transfers per owner while the other waits (>=1)
// ----------------------------------------------------------------------------
module tt_um_taghreed_eialsalman_mux_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    tt_um_taghreed_eialsalman_mux_rr_arbiter_if.slave bus
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic [CNT_W-1:0]  w_burst_cnt_nxt;
    logic              r_last_b;      // 1: B was the most recent owner
    logic              w_last_b_nxt;
    logic              r_sel;
    logic              w_sel_nxt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic              w_xfer_a;
    logic              w_xfer_b;

    // A transfer needs both the grant and a live request in the same cycle;
    // an owner dropping its request releases without moving data.
    assign w_xfer_a = (r_state == OWN_A) && bus.req_a;
    assign w_xfer_b = (r_state == OWN_B) && bus.req_b;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        w_last_b_nxt    = r_last_b;
        w_sel_nxt       = r_sel;

        case (r_state)
            IDLE: begin
                if (bus.req_a && bus.req_b)
                    w_state_nxt = r_last_b ? OWN_A : OWN_B;
                else if (bus.req_a)
                    w_state_nxt = OWN_A;
                else if (bus.req_b)
                    w_state_nxt = OWN_B;
            end
            OWN_A: begin
                if (!bus.req_a)
                    w_state_nxt = bus.req_b ? OWN_B : IDLE;
                else if (r_burst_cnt == CNT_LAST) begin
                    // Burst limit: hand over only if B is actually waiting,
                    // otherwise start a fresh burst for A.
                    if (bus.req_b)
                        w_state_nxt = OWN_B;
                    else
                        w_burst_cnt_nxt = '0;
                end else
                    w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            end
            OWN_B: begin
                if (!bus.req_b)
                    w_state_nxt = bus.req_a ? OWN_A : IDLE;
                else if (r_burst_cnt == CNT_LAST) begin
                    if (bus.req_a)
                        w_state_nxt = OWN_A;
                    else
                        w_burst_cnt_nxt = '0;
                end else
                    w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Leaving an owner state records who just left, so the next tie in
        // IDLE goes to the other side.
        if (w_state_nxt != r_state) begin
            w_burst_cnt_nxt = '0;
            if (r_state == OWN_A)
                w_last_b_nxt = 1'b0;
            else if (r_state == OWN_B)
                w_last_b_nxt = 1'b1;
        end

        // sel follows the new grant and holds through IDLE.
        if (w_state_nxt == OWN_A)
            w_sel_nxt = 1'b0;
        else if (w_state_nxt == OWN_B)
            w_sel_nxt = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_last_b    <= 1'b1;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_last_b    <= w_last_b_nxt;
            r_sel       <= w_sel_nxt;
            if (w_xfer_a) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.data_a;
            end else if (w_xfer_b) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.data_b;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Grants decode straight from the state register, so they are one-hot
    // and change only on a clock edge.
    assign bus.gnt_a     = (r_state == OWN_A);
    assign bus.gnt_b     = (r_state == OWN_B);
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_tt_um_taghreed_eialsalman_mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tt_um_taghreed_eialsalman_mux_rr_arbiter
//   Directed bench: a table of {inputs, expected outputs} rows applied one per
//   clock, plus hand-written sequences for reset mid-burst and MAX_BURST=1.
//   u_dut uses MAX_BURST=4, u_dut1 uses MAX_BURST=1; both share clk and rst.
// ----------------------------------------------------------------------------
module tb_tt_um_taghreed_eialsalman_mux_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tt_um_taghreed_eialsalman_mux_rr_arbiter_if #(.DATA_W(8)) bus0 ();
    tt_um_taghreed_eialsalman_mux_rr_arbiter_if #(.DATA_W(8)) bus1 ();

    tt_um_taghreed_eialsalman_mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    tt_um_taghreed_eialsalman_mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        logic       rst;
        logic       req_a;
        logic       req_b;
        logic [7:0] data_a;
        logic [7:0] data_b;
        logic       gnt_a;
        logic       gnt_b;
        logic       sel;
        logic       valid;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic r, logic ra, logic rb, logic [7:0] da, logic [7:0] db,
                                logic ga, logic gb, logic s, logic v, logic [7:0] d);
        vec_t t;
        t.rst = r;   t.req_a = ra; t.req_b = rb; t.data_a = da; t.data_b = db;
        t.gnt_a = ga; t.gnt_b = gb; t.sel = s;   t.valid = v;   t.data = d;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_outs0(input string name, input logic ga, input logic gb, input logic s,
                               input logic v, input logic [7:0] d);
        check({name, " gnt_a"},     32'(bus0.gnt_a),     32'(ga));
        check({name, " gnt_b"},     32'(bus0.gnt_b),     32'(gb));
        check({name, " sel"},       32'(bus0.sel),       32'(s));
        check({name, " out_valid"}, 32'(bus0.out_valid), 32'(v));
        check({name, " out_data"},  32'(bus0.out_data),  32'(d));
    endtask

    task automatic check_outs1(input string name, input logic ga, input logic gb, input logic s,
                               input logic v, input logic [7:0] d);
        check({name, " gnt_a"},     32'(bus1.gnt_a),     32'(ga));
        check({name, " gnt_b"},     32'(bus1.gnt_b),     32'(gb));
        check({name, " sel"},       32'(bus1.sel),       32'(s));
        check({name, " out_valid"}, 32'(bus1.out_valid), 32'(v));
        check({name, " out_data"},  32'(bus1.out_data),  32'(d));
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.req_a = 1'b0; bus0.req_b = 1'b0; bus0.data_a = '0; bus0.data_b = '0;
        bus1.req_a = 1'b0; bus1.req_b = 1'b0; bus1.data_a = '0; bus1.data_b = '0;

        // Columns: rst req_a req_b data_a data_b | gnt_a gnt_b sel valid data
        // Reset held two cycles with both requesting.
        vecs.push_back(mk(1,1,1,8'h11,8'h22, 0,0,0,0,8'h00));
        vecs.push_back(mk(1,1,1,8'h11,8'h22, 0,0,0,0,8'h00));
        // Single requester A, then release to IDLE.
        vecs.push_back(mk(0,1,0,8'h5A,8'h00, 1,0,0,0,8'h00));
        vecs.push_back(mk(0,1,0,8'h5A,8'h00, 1,0,0,1,8'h5A));
        vecs.push_back(mk(0,1,0,8'h5A,8'h00, 1,0,0,1,8'h5A));
        vecs.push_back(mk(0,0,0,8'h5A,8'h00, 0,0,0,0,8'h5A));
        vecs.push_back(mk(0,0,0,8'h00,8'h00, 0,0,0,0,8'h5A));
        // Reset, then a held tie: A wins, 4 each, no gap between owners.
        vecs.push_back(mk(1,1,1,8'hA0,8'hB0, 0,0,0,0,8'h00));
        vecs.push_back(mk(0,1,1,8'hA1,8'hB1, 1,0,0,0,8'h00));
        vecs.push_back(mk(0,1,1,8'hA2,8'hB2, 1,0,0,1,8'hA2));
        vecs.push_back(mk(0,1,1,8'hA3,8'hB3, 1,0,0,1,8'hA3));
        vecs.push_back(mk(0,1,1,8'hA4,8'hB4, 1,0,0,1,8'hA4));
        vecs.push_back(mk(0,1,1,8'hA5,8'hB5, 0,1,1,1,8'hA5));
        vecs.push_back(mk(0,1,1,8'hA6,8'hB6, 0,1,1,1,8'hB6));
        vecs.push_back(mk(0,1,1,8'hA7,8'hB7, 0,1,1,1,8'hB7));
        vecs.push_back(mk(0,1,1,8'hA8,8'hB8, 0,1,1,1,8'hB8));
        vecs.push_back(mk(0,1,1,8'hA9,8'hB9, 1,0,0,1,8'hB9));
        vecs.push_back(mk(0,1,1,8'hAA,8'hBA, 1,0,0,1,8'hAA));
        vecs.push_back(mk(0,1,1,8'hAB,8'hBB, 1,0,0,1,8'hAB));
        // Early release by A after 2 transfers: B gets a full fresh burst of 4.
        vecs.push_back(mk(0,0,1,8'hAC,8'hBC, 0,1,1,0,8'hAB));
        vecs.push_back(mk(0,1,1,8'hAD,8'hC1, 0,1,1,1,8'hC1));
        vecs.push_back(mk(0,1,1,8'hAE,8'hC2, 0,1,1,1,8'hC2));
        vecs.push_back(mk(0,1,1,8'hAF,8'hC3, 0,1,1,1,8'hC3));
        vecs.push_back(mk(0,1,1,8'hB0,8'hC4, 1,0,0,1,8'hC4));
        // A alone for 10 cycles: continuous grant, 10 contiguous valids.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0,1,0,8'(8'hD0 + i),8'h00, 1,0,0,1,8'(8'hD0 + i)));
        vecs.push_back(mk(0,0,0,8'h00,8'h00, 0,0,0,0,8'hD9));
        // B alone, then release: sel holds 1 through IDLE.
        vecs.push_back(mk(0,0,1,8'h00,8'hE1, 0,1,1,0,8'hD9));
        vecs.push_back(mk(0,0,1,8'h00,8'hE2, 0,1,1,1,8'hE2));
        vecs.push_back(mk(0,0,0,8'h00,8'h00, 0,0,1,0,8'hE2));
        vecs.push_back(mk(0,0,0,8'h00,8'h00, 0,0,1,0,8'hE2));

        foreach (vecs[i]) begin
            rst         = vecs[i].rst;
            bus0.req_a  = vecs[i].req_a;
            bus0.req_b  = vecs[i].req_b;
            bus0.data_a = vecs[i].data_a;
            bus0.data_b = vecs[i].data_b;
            tick();
            check_outs0($sformatf("vec%0d", i), vecs[i].gnt_a, vecs[i].gnt_b,
                        vecs[i].sel, vecs[i].valid, vecs[i].data);
        end

        // Reset mid-burst: reach OWN_B via A's release (so last=A), burst 2 deep.
        bus0.req_a = 1'b1; bus0.req_b = 1'b0; bus0.data_a = 8'h61;
        tick(); check_outs0("mid own_a", 1, 0, 0, 0, 8'hE2);
        bus0.req_a = 1'b0; bus0.req_b = 1'b1; bus0.data_b = 8'hF1;
        tick(); check_outs0("mid release", 0, 1, 1, 0, 8'hE2);
        bus0.data_b = 8'hF2;
        tick(); check_outs0("mid b1", 0, 1, 1, 1, 8'hF2);
        bus0.data_b = 8'hF3;
        tick(); check_outs0("mid b2", 0, 1, 1, 1, 8'hF3);
        rst = 1'b1; bus0.req_a = 1'b1; bus0.req_b = 1'b1;
        tick(); check_outs0("mid reset", 0, 0, 0, 0, 8'h00);
        rst = 1'b0; bus0.data_a = 8'h71; bus0.data_b = 8'h72;
        tick(); check_outs0("post reset tie", 1, 0, 0, 0, 8'h00);
        tick(); check_outs0("post reset xfer", 1, 0, 0, 1, 8'h71);

        // MAX_BURST=1: strict alternation with both requesting every cycle.
        bus0.req_a = 1'b0; bus0.req_b = 1'b0;
        rst = 1'b1;
        tick(); check_outs1("mb1 reset", 0, 0, 0, 0, 8'h00);
        rst = 1'b0;
        bus1.req_a = 1'b1; bus1.req_b = 1'b1; bus1.data_a = 8'h11; bus1.data_b = 8'h22;
        tick(); check_outs1("mb1 first", 1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k % 2 == 0)
                check_outs1($sformatf("mb1 step%0d", k), 0, 1, 1, 1, 8'h11);
            else
                check_outs1($sformatf("mb1 step%0d", k), 1, 0, 0, 1, 8'h22);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
